// File: rtl/eth_speed_detect.sv
// eth_speed_detect: classifies the PHY link as 10M/100M/1000M by counting
// synchronised rx_toggle edges against a gtx-clock reference window.
// It applies hysteresis, watches for a lost rx clock, emits a one-cycle
// speed_change event and lets configuration force the reported speed.
module eth_speed_detect #(
    parameter int REF_CNT_WIDTH  = 7,
    parameter int EDGE_CNT_WIDTH = 2,
    parameter int THRESH_100M    = 32,
    parameter int STABLE_COUNT   = 2,
    parameter int NOCLK_WIDTH    = 12,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_toggle,
    input  logic       cfg_force_en,
    input  logic [1:0] cfg_force_speed,
    output logic [1:0] speed,
    output logic       mii_select,
    output logic       speed_valid,
    output logic       speed_change,
    output logic       clk_lost
);

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;

    localparam int STW = $clog2(STABLE_COUNT + 1);

    localparam logic [REF_CNT_WIDTH-1:0]  REF_MAX    = '1;
    localparam logic [REF_CNT_WIDTH-1:0]  REF_ONE    = REF_CNT_WIDTH'(1);
    localparam logic [REF_CNT_WIDTH-1:0]  REF_THRESH = REF_CNT_WIDTH'(THRESH_100M);
    localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_MAX   = '1;
    localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_ONE   = EDGE_CNT_WIDTH'(1);
    localparam logic [NOCLK_WIDTH-1:0]    NOCLK_MAX  = '1;
    localparam logic [NOCLK_WIDTH-1:0]    NOCLK_ONE  = NOCLK_WIDTH'(1);
    localparam logic [STW-1:0]            STABLE_MAX = STW'(STABLE_COUNT);
    localparam logic [STW-1:0]            STABLE_ONE = STW'(1);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      edge_det;
    logic [REF_CNT_WIDTH-1:0]  ref_cnt;
    logic [EDGE_CNT_WIDTH-1:0] edge_cnt;
    logic [NOCLK_WIDTH-1:0]    noclk_cnt, noclk_nxt;
    logic [1:0]                last_cand, last_cand_nxt, cand;
    logic [STW-1:0]            stable_cnt, stable_nxt;
    logic [1:0]                meas_speed;
    logic                      meas_valid;
    logic                      edge_term, ref_term, win_end;
    logic [1:0]                spd_nxt;
    logic                      vld_nxt;

    // The last two synchroniser stages are metastability-settled; their XOR is one rx_toggle edge.
    assign edge_det = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];

    // Shift rx_toggle into the gtx domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_toggle};
    end

    // Window terminal detection; the edge terminal takes priority over ref overflow.
    always_comb begin
        edge_term = (edge_cnt == EDGE_MAX);
        ref_term  = (ref_cnt == REF_MAX);
        win_end   = edge_term | ref_term;
        cand      = SPD_10;
        if (edge_term) cand = (ref_cnt >= REF_THRESH) ? SPD_100 : SPD_1000;
    end

    // Reference and edge counters; both restart together at window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            edge_cnt <= '0;
        end else if (win_end) begin
            ref_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + REF_ONE;
            if (edge_det) edge_cnt <= edge_cnt + EDGE_ONE;
        end
    end

    // Watchdog: count cycles since the last edge, parking at all-ones.
    always_comb begin
        noclk_nxt = noclk_cnt;
        if (edge_det)                 noclk_nxt = '0;
        else if (noclk_cnt != NOCLK_MAX) noclk_nxt = noclk_cnt + NOCLK_ONE;
    end

    // Watchdog state; clk_lost mirrors the saturated counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noclk_cnt <= '0;
            clk_lost  <= 1'b0;
        end else begin
            noclk_cnt <= noclk_nxt;
            clk_lost  <= (noclk_nxt == NOCLK_MAX);
        end
    end

    // Hysteresis: count consecutive agreeing candidates; a lost clock discards history.
    always_comb begin
        last_cand_nxt = last_cand;
        stable_nxt    = stable_cnt;
        if (clk_lost) begin
            stable_nxt = '0;
        end else if (win_end) begin
            if (cand == last_cand) begin
                if (stable_cnt != STABLE_MAX) stable_nxt = stable_cnt + STABLE_ONE;
            end else begin
                last_cand_nxt = cand;
                stable_nxt    = STABLE_ONE;
            end
        end
    end

    // Hysteresis state and the qualified measured speed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cand  <= SPD_10;
            stable_cnt <= '0;
            meas_speed <= SPD_1000;
            meas_valid <= 1'b0;
        end else begin
            last_cand  <= last_cand_nxt;
            stable_cnt <= stable_nxt;
            if (clk_lost) begin
                meas_valid <= 1'b0;
            end else if (win_end && stable_nxt == STABLE_MAX) begin
                meas_speed <= last_cand_nxt;
                meas_valid <= 1'b1;
            end
        end
    end

    // Output select: forced speed (11 reads as 1000M) or the measured result.
    always_comb begin
        spd_nxt = meas_speed;
        vld_nxt = meas_valid & ~clk_lost;
        if (cfg_force_en) begin
            spd_nxt = (cfg_force_speed == 2'b11) ? SPD_1000 : cfg_force_speed;
            vld_nxt = 1'b1;
        end
    end

    // Registered outputs; speed_change fires on a new speed or a rising valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed        <= SPD_1000;
            speed_valid  <= 1'b0;
            mii_select   <= 1'b0;
            speed_change <= 1'b0;
        end else begin
            speed        <= spd_nxt;
            speed_valid  <= vld_nxt;
            mii_select   <= (spd_nxt != SPD_1000);
            speed_change <= (spd_nxt != speed) | (vld_nxt & ~speed_valid);
        end
    end

endmodule

// File: tb/tb_eth_speed_detect.sv
// Bench for eth_speed_detect: directed toggle-rate phases, a window-history
// reference model checked every cycle, and hand-computed phase-end checks.
module tb_eth_speed_detect;

    localparam int REF_W   = 7;
    localparam int EDGE_W  = 2;
    localparam int THRESH  = 32;
    localparam int STABLE  = 2;
    localparam int NOCLK_W = 12;
    localparam int SYNC    = 3;

    localparam int RMAX = (1 << REF_W) - 1;
    localparam int EMAX = (1 << EDGE_W) - 1;
    localparam int NMAX = (1 << NOCLK_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_toggle = 1'b0;
    logic       cfg_force_en = 1'b0;
    logic [1:0] cfg_force_speed = 2'b00;
    logic [1:0] speed;
    logic       mii_select, speed_valid, speed_change, clk_lost;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;
    int tog_half = 0;

    eth_speed_detect #(
        .REF_CNT_WIDTH(REF_W), .EDGE_CNT_WIDTH(EDGE_W), .THRESH_100M(THRESH),
        .STABLE_COUNT(STABLE), .NOCLK_WIDTH(NOCLK_W), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_toggle(rx_toggle),
        .cfg_force_en(cfg_force_en), .cfg_force_speed(cfg_force_speed),
        .speed(speed), .mii_select(mii_select), .speed_valid(speed_valid),
        .speed_change(speed_change), .clk_lost(clk_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // rx_toggle source: flips every tog_half clk cycles, held while tog_half is 0.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (tog_half != 0) begin
                cnt++;
                if (cnt >= tog_half) begin
                    rx_toggle = ~rx_toggle;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Reference model: windows are measured in cycles/edges, hysteresis is
    // "the last STABLE window results all agree", and outputs follow the
    // measurement one cycle later.
    logic [SYNC-1:0] m_hist;
    int              m_len, m_edges, m_quiet;
    logic [1:0]      m_meas;
    bit              m_mvalid;
    logic [1:0]      cand_q[$];
    logic [1:0]      e_speed;
    bit              e_valid, e_change, e_mii, e_lost;

    initial begin
        bit         edge_s, lost_b, v, same;
        logic [1:0] sp, c;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_hist = '0; m_len = 0; m_edges = 0; m_quiet = 0;
                m_meas = 2'b10; m_mvalid = 0; cand_q.delete();
                e_speed = 2'b10; e_valid = 0; e_change = 0; e_mii = 0; e_lost = 0;
            end else begin
                edge_s = m_hist[SYNC-1] ^ m_hist[SYNC-2];
                lost_b = (m_quiet == NMAX);
                if (cfg_force_en) begin
                    sp = (cfg_force_speed == 2'b11) ? 2'b10 : cfg_force_speed;
                    v  = 1;
                end else begin
                    sp = m_meas;
                    v  = m_mvalid && !lost_b;
                end
                e_change = (sp != e_speed) || (v && !e_valid);
                e_speed  = sp;
                e_valid  = v;
                e_mii    = (sp != 2'b10);
                if (m_edges == EMAX || m_len == RMAX) begin
                    c = (m_edges == EMAX) ? ((m_len >= THRESH) ? 2'b01 : 2'b10) : 2'b00;
                    m_len = 0;
                    m_edges = 0;
                    if (!lost_b) begin
                        cand_q.push_back(c);
                        if (cand_q.size() > STABLE) void'(cand_q.pop_front());
                        if (cand_q.size() == STABLE) begin
                            same = 1;
                            foreach (cand_q[i]) if (cand_q[i] != c) same = 0;
                            if (same) begin
                                m_meas = c;
                                m_mvalid = 1;
                            end
                        end
                    end
                end else begin
                    m_len++;
                    if (edge_s) m_edges++;
                end
                if (lost_b) begin
                    cand_q.delete();
                    m_mvalid = 0;
                end
                if (edge_s)              m_quiet = 0;
                else if (m_quiet < NMAX) m_quiet++;
                e_lost = (m_quiet == NMAX);
                m_hist = {m_hist[SYNC-2:0], rx_toggle};
            end
        end
    end

    // Per-cycle compare against the model, also tallying speed_change pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("speed", speed, e_speed);
            check("speed_valid", speed_valid, e_valid);
            check("mii_select", mii_select, e_mii);
            check("speed_change", speed_change, e_change);
            check("clk_lost", clk_lost, e_lost);
            if (speed_change) pulses++;
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        run(4);
        #1;
        check("rst_speed", speed, 2);
        check("rst_valid", speed_valid, 0);
        check("rst_mii", mii_select, 0);
        check("rst_change", speed_change, 0);
        check("rst_lost", clk_lost, 0);

        // 1000M: toggle every 4 clk
        @(negedge clk);
        rst_n = 1'b1;
        tog_half = 4;
        pulses = 0;
        run(100);
        check("g_speed", speed, 2);
        check("g_valid", speed_valid, 1);
        check("g_mii", mii_select, 0);
        check("g_pulses", pulses, 1);

        // 100M: toggle every 20 clk
        tog_half = 20;
        pulses = 0;
        run(250);
        check("f_speed", speed, 1);
        check("f_mii", mii_select, 1);
        check("f_valid", speed_valid, 1);
        check("f_pulses", pulses, 1);

        // 10M: toggle every 200 clk, ref overflow ends each window
        tog_half = 200;
        pulses = 0;
        run(700);
        check("t_speed", speed, 0);
        check("t_mii", mii_select, 1);
        check("t_lost", clk_lost, 0);
        check("t_pulses", pulses, 1);

        // Brief 100M, back to 1000M, then sustained 100M
        tog_half = 20;
        run(20);
        tog_half = 4;
        run(80);
        check("sw_1000_speed", speed, 2);
        tog_half = 20;
        pulses = 0;
        run(300);
        check("sw_100_speed", speed, 1);
        check("sw_pulses", pulses, 1);

        // Stop the rx clock
        tog_half = 0;
        run(4300);
        check("lost_flag", clk_lost, 1);
        check("lost_valid", speed_valid, 0);
        tog_half = 4;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!clk_lost) break;
        end
        check("lost_clear", clk_lost, 0);
        run(100);
        check("relock_valid", speed_valid, 1);
        check("relock_speed", speed, 2);

        // Force 11 -> reads as 1000M, no event
        pulses = 0;
        cfg_force_speed = 2'b11;
        cfg_force_en = 1'b1;
        run(20);
        check("f11_speed", speed, 2);
        check("f11_pulses", pulses, 0);
        cfg_force_speed = 2'b01;
        run(20);
        check("f01_speed", speed, 1);
        check("f01_mii", mii_select, 1);
        check("f01_pulses", pulses, 1);
        cfg_force_en = 1'b0;
        run(20);
        check("rel_speed", speed, 2);
        check("rel_mii", mii_select, 0);
        check("rel_pulses", pulses, 2);

        // Reset in the middle of a window
        run(5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_speed", speed, 2);
        check("mid_rst_valid", speed_valid, 0);
        check("mid_rst_mii", mii_select, 0);
        check("mid_rst_change", speed_change, 0);
        check("mid_rst_lost", clk_lost, 0);
        run(3);
        rst_n = 1'b1;
        run(100);
        check("post_rst_valid", speed_valid, 1);
        check("post_rst_speed", speed, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
